// File: rtl/aoi4_cell_checker.sv
// ---------------------------------------------------------------------------
// aoi4_cell_checker
//
// Sequential self-test engine for a 4-input AND-NOR cell,
// Z = !((A&B)|C|D). It walks all 16 input vectors into the cell under test.
// Each vector is held for SETTLE_CYCLES cycles. The cell's Z output is then
// sampled and judged against a golden model. The block reports pass/fail, a
// saturating mismatch count and the first failing vector.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before Z_IN is sampled (1..15)
//   NUM_PASSES     full 16-vector sweeps per run (1..255)
//   ERR_W          width of the saturating mismatch counter
//
// Ports
//   CP          clock, rising edge
//   RST         synchronous reset, active-high
//   START       begin a run (honoured only in IDLE or DONE_S)
//   Z_IN        observed output of the cell under test
//   A,B,C,D     stimulus, {A,B,C,D} = vec[3:0]
//   BUSY        high while settling or sampling
//   DONE        high once a run has finished, held until the next START
//   PASS        valid with DONE; 1 = no mismatches (and not stuck)
//   ERR_COUNT   mismatch count, saturates at all-ones
//   FAIL_VEC    {A,B,C,D} of the first mismatch
//   FAIL_VALID  FAIL_VEC holds a captured value
//   STUCK       Z_IN never toggled during the run (optional feature)
//
// Optional feature macro: AOI4_STUCK_DETECT_EN
//   defined   -> track whether Z_IN was ever seen at 0 and at 1 during a run.
//                STUCK is flagged on completion and forces PASS low.
//   undefined -> STUCK is tied low and no flag logic is built.
//
// State table
//   state  | meaning
//   IDLE   | waiting for START, outputs hold their last values
//   SETTLE | vector driven, counting down the settle time
//   SAMPLE | one cycle: judge Z_IN, advance vector or finish
//   DONE_S | run complete, verdict outputs valid, A..D = 4'b1111
// ---------------------------------------------------------------------------
module aoi4_cell_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 1,
   parameter int ERR_W         = 5
) (
   input  logic             CP,
   input  logic             RST,
   input  logic             START,
   input  logic             Z_IN,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_COUNT,
   output logic [3:0]       FAIL_VEC,
   output logic             FAIL_VALID,
   output logic             STUCK
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE_S = 2'd3
   } state_t;

   localparam logic [3:0]       SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       LAST_PASS     = 8'(NUM_PASSES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX       = '1;
   localparam logic [ERR_W-1:0] ERR_ONE       = ERR_W'(1);

   state_t           state_q, state_nxt;
   logic [3:0]       vec_q, vec_nxt;
   logic [3:0]       settle_q, settle_nxt;
   logic [7:0]       pass_cnt_q, pass_cnt_nxt;
   logic [ERR_W-1:0] err_q, err_nxt;
   logic [3:0]       fail_vec_q, fail_vec_nxt;
   logic             fail_valid_q, fail_valid_nxt;
   logic             pass_q, pass_nxt;

   logic             gold;
   logic             mismatch;
   logic             last_sample;
   logic             run_start;
   logic             stuck_verdict;

   assign gold        = ~((vec_q[3] & vec_q[2]) | vec_q[1] | vec_q[0]);
   assign mismatch    = (state_q == SAMPLE) && (Z_IN != gold);
   // The final sample of the final sweep; the run ends on this edge.
   assign last_sample = (state_q == SAMPLE) && (vec_q == 4'hF) &&
                        (pass_cnt_q == LAST_PASS);
   assign run_start   = START && ((state_q == IDLE) || (state_q == DONE_S));

   // ------------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state_q;
      vec_nxt        = vec_q;
      settle_nxt     = settle_q;
      pass_cnt_nxt   = pass_cnt_q;
      err_nxt        = err_q;
      fail_vec_nxt   = fail_vec_q;
      fail_valid_nxt = fail_valid_q;
      pass_nxt       = pass_q;

      case (state_q)
         IDLE, DONE_S: begin
            if (run_start) begin
               state_nxt      = SETTLE;
               vec_nxt        = 4'h0;
               settle_nxt     = SETTLE_RELOAD;
               pass_cnt_nxt   = 8'h00;
               err_nxt        = '0;
               fail_vec_nxt   = 4'h0;
               fail_valid_nxt = 1'b0;
               pass_nxt       = 1'b0;
            end
         end

         SETTLE: begin
            if (settle_q == 4'h0) begin
               state_nxt = SAMPLE;
            end else begin
               settle_nxt = settle_q - 4'd1;
            end
         end

         SAMPLE: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_nxt = err_q + ERR_ONE;
               end
               if (!fail_valid_q) begin
                  fail_vec_nxt   = vec_q;
                  fail_valid_nxt = 1'b1;
               end
            end

            if (last_sample) begin
               // Verdict includes the mismatch judged on this very edge.
               state_nxt = DONE_S;
               pass_nxt  = (err_nxt == '0) && !stuck_verdict;
            end else begin
               state_nxt  = SETTLE;
               vec_nxt    = vec_q + 4'd1;
               settle_nxt = SETTLE_RELOAD;
               if (vec_q == 4'hF) begin
                  pass_cnt_nxt = pass_cnt_q + 8'd1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CP) begin
      if (RST) begin
         state_q      <= IDLE;
         vec_q        <= 4'h0;
         settle_q     <= 4'h0;
         pass_cnt_q   <= 8'h00;
         err_q        <= '0;
         fail_vec_q   <= 4'h0;
         fail_valid_q <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         vec_q        <= vec_nxt;
         settle_q     <= settle_nxt;
         pass_cnt_q   <= pass_cnt_nxt;
         err_q        <= err_nxt;
         fail_vec_q   <= fail_vec_nxt;
         fail_valid_q <= fail_valid_nxt;
         pass_q       <= pass_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Stuck-output detection
   // ------------------------------------------------------------------------
`ifdef AOI4_STUCK_DETECT_EN
   logic seen0_q, seen1_q, stuck_q;
   logic seen0_nxt, seen1_nxt;

   always_comb begin
      seen0_nxt = seen0_q;
      seen1_nxt = seen1_q;
      if (run_start) begin
         seen0_nxt = 1'b0;
         seen1_nxt = 1'b0;
      end else if (state_q == SAMPLE) begin
         seen0_nxt = seen0_q | ~Z_IN;
         seen1_nxt = seen1_q | Z_IN;
      end
   end

   // Uses the flags as they stand after this edge's sample.
   assign stuck_verdict = ~(seen0_nxt & seen1_nxt);

   always_ff @(posedge CP) begin
      if (RST) begin
         seen0_q <= 1'b0;
         seen1_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         seen0_q <= seen0_nxt;
         seen1_q <= seen1_nxt;
         if (run_start) begin
            stuck_q <= 1'b0;
         end else if (last_sample) begin
            stuck_q <= stuck_verdict;
         end
      end
   end

   assign STUCK = stuck_q;
`else
   assign stuck_verdict = 1'b0;
   assign STUCK         = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign {A, B, C, D} = vec_q;
   assign BUSY         = (state_q == SETTLE) || (state_q == SAMPLE);
   assign DONE         = (state_q == DONE_S);
   assign PASS         = pass_q;
   assign ERR_COUNT    = err_q;
   assign FAIL_VEC     = fail_vec_q;
   assign FAIL_VALID   = fail_valid_q;

endmodule

// File: tb/tb_aoi4_cell_checker.sv
// ---------------------------------------------------------------------------
// tb_aoi4_cell_checker
//
// Three checker instances with different parameter sets, each driven by a
// behavioural cell model selected per run. Stimulus pushes the hand-computed
// verdict of each run into a per-instance queue; per-instance monitors pop
// and compare when DONE rises.
// ---------------------------------------------------------------------------
module tb_aoi4_cell_checker;

`ifdef AOI4_STUCK_DETECT_EN
   localparam bit STUCK_EN = 1'b1;
`else
   localparam bit STUCK_EN = 1'b0;
`endif

   typedef struct {
      bit         pass;
      int         err;
      logic [3:0] fvec;
      bit         fvalid;
      bit         stuck;
      int         lat;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int ts_a     = 0;
   int ts_b     = 0;
   int ts_c     = 0;

   logic CP = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   int   mode_a = 0, mode_b = 0, mode_c = 0;

   logic       z_a, a_a, b_a, c_a, d_a, busy_a, done_a, pass_a, fvalid_a, stuck_a;
   logic [4:0] err_a;
   logic [3:0] fvec_a;
   logic       z_b, a_b, b_b, c_b, d_b, busy_b, done_b, pass_b, fvalid_b, stuck_b;
   logic [2:0] err_b;
   logic [3:0] fvec_b;
   logic       z_c, a_c, b_c, c_c, d_c, busy_c, done_c, pass_c, fvalid_c, stuck_c;
   logic [4:0] err_c;
   logic [3:0] fvec_c;

   always #5 CP = ~CP;
   always @(posedge CP) cyc <= cyc + 1;

   // Cell models: 0 ideal, 1 C ignored, 2 stuck-at-0, 3 stuck-at-1,
   // 4 ideal only in the cycle before each sampling edge, inverted otherwise.
   function automatic logic zmodel(int mode, logic [3:0] v, int rel, int per);
      logic ideal;
      ideal = ~((v[3] & v[2]) | v[1] | v[0]);
      case (mode)
         1:       zmodel = ~((v[3] & v[2]) | v[0]);
         2:       zmodel = 1'b0;
         3:       zmodel = 1'b1;
         4:       zmodel = ideal ^ (((rel + 1) % per) != 0);
         default: zmodel = ideal;
      endcase
   endfunction

   assign z_a = zmodel(mode_a, {a_a, b_a, c_a, d_a}, cyc - ts_a, 3);
   assign z_b = zmodel(mode_b, {a_b, b_b, c_b, d_b}, cyc - ts_b, 3);
   assign z_c = zmodel(mode_c, {a_c, b_c, c_c, d_c}, cyc - ts_c, 4);

   aoi4_cell_checker u_a (
      .CP(CP), .RST(rst), .START(start_a), .Z_IN(z_a),
      .A(a_a), .B(b_a), .C(c_a), .D(d_a),
      .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_COUNT(err_a),
      .FAIL_VEC(fvec_a), .FAIL_VALID(fvalid_a), .STUCK(stuck_a)
   );

   aoi4_cell_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(4), .ERR_W(3)) u_b (
      .CP(CP), .RST(rst), .START(start_b), .Z_IN(z_b),
      .A(a_b), .B(b_b), .C(c_b), .D(d_b),
      .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_COUNT(err_b),
      .FAIL_VEC(fvec_b), .FAIL_VALID(fvalid_b), .STUCK(stuck_b)
   );

   aoi4_cell_checker #(.SETTLE_CYCLES(3), .NUM_PASSES(1), .ERR_W(5)) u_c (
      .CP(CP), .RST(rst), .START(start_c), .Z_IN(z_c),
      .A(a_c), .B(b_c), .C(c_c), .D(d_c),
      .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .ERR_COUNT(err_c),
      .FAIL_VEC(fvec_c), .FAIL_VALID(fvalid_c), .STUCK(stuck_c)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(bit p, int err, logic [3:0] fv, bit fval, bit st, int lat);
      exp_t e;
      e.pass = p; e.err = err; e.fvec = fv; e.fvalid = fval; e.stuck = st; e.lat = lat;
      return e;
   endfunction

   task automatic check_result(string nm, exp_t e, logic p, logic [31:0] err,
                               logic [3:0] fv, logic fval, logic st, int lat,
                               logic [3:0] abcd);
      chk({nm, ".pass"},       32'(p),    32'(e.pass));
      chk({nm, ".err_count"},  err,       32'(e.err));
      chk({nm, ".fail_vec"},   32'(fv),   32'(e.fvec));
      chk({nm, ".fail_valid"}, 32'(fval), 32'(e.fvalid));
      chk({nm, ".stuck"},      32'(st),   32'(e.stuck));
      chk({nm, ".latency"},    32'(lat),  32'(e.lat));
      chk({nm, ".abcd"},       32'(abcd), 32'hF);
   endtask

   // ---------------- monitors ----------------
   logic pd_a = 1'b0, pd_b = 1'b0, pd_c = 1'b0;
   exp_t e_a, e_b, e_c;

   always @(negedge CP) begin
      if (start_a && busy_a !== 1'b1) ts_a = cyc + 1;
      if (done_a === 1'b1 && pd_a !== 1'b1) begin
         if (q_a.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_done inst a: DONE rose, expected no result");
         end else begin
            e_a = q_a.pop_front();
            check_result("a", e_a, pass_a, 32'(err_a), fvec_a, fvalid_a, stuck_a,
                         cyc - ts_a, {a_a, b_a, c_a, d_a});
         end
      end
      pd_a = done_a;
   end

   always @(negedge CP) begin
      if (start_b && busy_b !== 1'b1) ts_b = cyc + 1;
      if (done_b === 1'b1 && pd_b !== 1'b1) begin
         if (q_b.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_done inst b: DONE rose, expected no result");
         end else begin
            e_b = q_b.pop_front();
            check_result("b", e_b, pass_b, 32'(err_b), fvec_b, fvalid_b, stuck_b,
                         cyc - ts_b, {a_b, b_b, c_b, d_b});
         end
      end
      pd_b = done_b;
   end

   always @(negedge CP) begin
      if (start_c && busy_c !== 1'b1) ts_c = cyc + 1;
      if (done_c === 1'b1 && pd_c !== 1'b1) begin
         if (q_c.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_done inst c: DONE rose, expected no result");
         end else begin
            e_c = q_c.pop_front();
            check_result("c", e_c, pass_c, 32'(err_c), fvec_c, fvalid_c, stuck_c,
                         cyc - ts_c, {a_c, b_c, c_c, d_c});
         end
      end
      pd_c = done_c;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   function automatic int qsize(int w);
      case (w)
         0:       qsize = q_a.size();
         1:       qsize = q_b.size();
         default: qsize = q_c.size();
      endcase
   endfunction

   task automatic wait_q(int w, int budget);
      for (int i = 0; i < budget; i++) begin
         if (qsize(w) == 0) break;
         @(negedge CP);
      end
      if (qsize(w) != 0) begin
         n_checks++; n_err++;
         $display("FAIL timeout inst %0d: %0d results still pending, expected 0", w, qsize(w));
         case (w)
            0:       q_a.delete();
            1:       q_b.delete();
            default: q_c.delete();
         endcase
      end
   endtask

   task automatic go(int w);
      tick();
      case (w)
         0:       start_a = 1'b1;
         1:       start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      tick();
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      case (w)
         0:       chk("busy_after_start_a", 32'(busy_a), 32'd1);
         1:       chk("busy_after_start_b", 32'(busy_b), 32'd1);
         default: chk("busy_after_start_c", 32'(busy_c), 32'd1);
      endcase
   endtask

   task automatic chk_reset_a(string nm);
      chk({nm, ".abcd"},       32'({a_a, b_a, c_a, d_a}), 32'd0);
      chk({nm, ".busy"},       32'(busy_a),   32'd0);
      chk({nm, ".done"},       32'(done_a),   32'd0);
      chk({nm, ".pass"},       32'(pass_a),   32'd0);
      chk({nm, ".err_count"},  32'(err_a),    32'd0);
      chk({nm, ".fail_vec"},   32'(fvec_a),   32'd0);
      chk({nm, ".fail_valid"}, 32'(fvalid_a), 32'd0);
      chk({nm, ".stuck"},      32'(stuck_a),  32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      tick();
      tick();
      chk_reset_a("reset_a");
      chk("reset_b.busy", 32'(busy_b), 32'd0);
      chk("reset_c.done", 32'(done_c), 32'd0);
      rst = 1'b0;
      tick();

      // ideal cell, defaults
      mode_a = 0; q_a.push_back(mk(1, 0, 4'h0, 0, 0, 48)); go(0); wait_q(0, 120);
      // C input ignored: mismatches at 2, 6, 10
      mode_a = 1; q_a.push_back(mk(0, 3, 4'h2, 1, 0, 48)); go(0); wait_q(0, 120);
      // Z correct only in the sampling cycle
      mode_a = 4; q_a.push_back(mk(1, 0, 4'h0, 0, 0, 48)); go(0); wait_q(0, 120);

      // stuck-at-0, four passes, 3-bit counter saturates at 7
      mode_b = 2; q_b.push_back(mk(0, 7, 4'h0, 1, STUCK_EN, 192)); go(1); wait_q(1, 400);
      mode_b = 0; q_b.push_back(mk(1, 0, 4'h0, 0, 0, 192));        go(1); wait_q(1, 400);

      // settle time 3
      mode_c = 0; q_c.push_back(mk(1, 0, 4'h0, 0, 0, 64));         go(2); wait_q(2, 150);
      // stuck-at-1: 13 mismatches, first at vec 1
      mode_c = 3; q_c.push_back(mk(0, 13, 4'h1, 1, STUCK_EN, 64)); go(2); wait_q(2, 150);

      // reset during vec 9
      mode_a = 1;
      go(0);
      repeat (27) tick();
      chk("midrun.abcd",       32'({a_a, b_a, c_a, d_a}), 32'd9);
      chk("midrun.err_count",  32'(err_a),    32'd2);
      chk("midrun.fail_vec",   32'(fvec_a),   32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_a("midrun_reset");
      repeat (3) tick();
      chk("midrun_idle.busy", 32'(busy_a), 32'd0);
      mode_a = 0; q_a.push_back(mk(1, 0, 4'h0, 0, 0, 48)); go(0); wait_q(0, 120);

      // START during BUSY ignored, START in DONE_S restarts
      mode_a = 1; q_a.push_back(mk(0, 3, 4'h2, 1, 0, 48)); go(0);
      repeat (10) tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("busy_restart.busy", 32'(busy_a), 32'd1);
      wait_q(0, 120);
      mode_a = 0; q_a.push_back(mk(1, 0, 4'h0, 0, 0, 48)); go(0);
      chk("restart.done",       32'(done_a),   32'd0);
      chk("restart.err_count",  32'(err_a),    32'd0);
      chk("restart.fail_valid", 32'(fvalid_a), 32'd0);
      wait_q(0, 120);

      // RST and START on the same edge
      tick();
      rst = 1'b1; start_a = 1'b1;
      tick();
      rst = 1'b0; start_a = 1'b0;
      chk("rst_start.busy", 32'(busy_a), 32'd0);
      chk("rst_start.done", 32'(done_a), 32'd0);
      repeat (3) tick();
      chk("rst_start_idle.busy", 32'(busy_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
